// File: rtl/stpu_div_pkg.sv
// rtl/stpu_div_pkg.sv - shared state codes and handshake constants for the STPU divider
package stpu_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/stpu_div.sv
// rtl/stpu_div.sv - iterative restoring DIV/DIVU unit for HI/LO write-back
// Optional early-out for |divisor| > |dividend| enabled by STPU_DIV_EARLY_OUT_EN.
module stpu_div
  import stpu_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int               DOUBLE_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   dsr_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [DOUBLE_W-1:0] result_q;
  logic                ready_q;

  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;
  logic [DATA_W:0]     partial;
  logic [DATA_W:0]     diff;
  logic                qbit;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // The most negative value negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    op1_neg = signed_i & opdata1_i[DATA_W-1];
    op2_neg = signed_i & opdata2_i[DATA_W-1];
    op1_mag = op1_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    op2_mag = op2_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
    partial = {rem_q, quo_q[DATA_W-1]};
    diff    = partial - {1'b0, dsr_q};
    qbit    = ~diff[DATA_W];
    quo_fix = neg_quo_q ? (~quo_q + DATA_W'(1)) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + DATA_W'(1)) : rem_q;
  end

`ifdef STPU_DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = op2_mag > op1_mag;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i == DIV_START && !annul_i) begin
            neg_quo_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            dsr_q     <= op2_mag;
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_ON;
`ifdef STPU_DIV_EARLY_OUT_EN
              if (early_out) begin
                cnt_q <= LAST_CNT;
                rem_q <= op1_mag;
                quo_q <= '0;
              end else
`endif
              begin
                cnt_q <= '0;
                rem_q <= '0;
                quo_q <= op1_mag;
              end
            end
          end
        end
        DIV_BYZERO: begin
          result_q <= '0;
          if (annul_i) begin
            state_q <= DIV_FREE;
            ready_q <= DIV_RESULT_NOT_READY;
          end else begin
            state_q <= DIV_END;
            ready_q <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q  <= DIV_END;
            ready_q  <= DIV_RESULT_READY;
            result_q <= {rem_fix, quo_fix};
          end else begin
            // Restore by keeping the shifted partial remainder when the trial subtract borrows.
            rem_q <= qbit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], qbit};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
          end
        end
        default: state_q <= DIV_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != DIV_FREE);

endmodule
